mio_bus_arbiter: RTL and testbench
==================================

Name: mio_bus_arbiter

Overview:
- Two-master, one-slave arbiter and sequencer for the MIO data bus.
- Shares the memory/peripheral data path between the CPU data port (CPU_MIO / mem_w / Addr_out / Data_out / MIO_ready) and a DMA master.
- Registers the winning request, drives a single slave transaction with timeout protection, and returns data plus a one-cycle ready to the winner only.

Parameters:
- TIMEOUT, 16, s_ack-low cycles in XFER before abort (≥2).
- CPU_PRIO, 1, 1: CPU wins every tie; 0: round-robin on ties.
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req  in  1  CPU bus request (CPU_MIO), held until cpu_ready.
- cpu_we  in  1  CPU write enable (mem_w).
- cpu_addr  in  32  CPU address.
- cpu_wdata  in  32  CPU write data.
- cpu_rdata  out  32  read data to CPU.
- cpu_ready  out  1  transfer-complete pulse to CPU (MIO_ready).
- dma_req  in  1  DMA request, held until dma_ready.
- dma_we  in  1  DMA write enable.
- dma_addr  in  32  DMA address.
- dma_wdata  in  32  DMA write data.
- dma_rdata  out  32  read data to DMA.
- dma_ready  out  1  transfer-complete pulse to DMA.
- s_req  out  1  slave request.
- s_we  out  1  slave write enable.
- s_addr  out  32  slave address.
- s_wdata  out  32  slave write data.
- s_rdata  in  32  slave read data, valid when s_ack=1.
- s_ack  in  1  slave acknowledge.
- bus_err  out  1  one-cycle pulse with ready on timeout.
- owner  out  1  current/last grant: 0 = CPU, 1 = DMA.

Behaviour:
- **Reset (async, rst_n=0):** all outputs 0; state IDLE; owner 0; last_owner = DMA, so the CPU wins the first tie in RR mode; timeout counter 0.
- **FSM IDLE -> XFER -> DONE -> IDLE.** All outputs are registered.
- **IDLE:**
  - If any req is high, pick a winner.
    - One requester: that requester wins.
    - Both, CPU_PRIO=1: CPU wins.
    - Both, CPU_PRIO=0: the master that is not last_owner wins.
  - Latch the winner's we/addr/wdata into s_we/s_addr/s_wdata; set s_req=1, owner, last_owner; go to XFER.
  - With no request: s_req=0 and s_we/s_addr/s_wdata hold their last values.
- **XFER:**
  - s_req and latched fields stay stable; requester changes are ignored (no cancellation).
  - On s_ack=1 at a clock edge: capture s_rdata into the winner's rdata register, drop s_req, go to DONE.
  - Counter increments each s_ack-low cycle. When it reaches TIMEOUT-1 with s_ack still low: drop s_req, load ERR_DATA into the winner's rdata, set error flag, go to DONE.
- **DONE:**
  - Winner's ready=1 for exactly this cycle; bus_err=1 if aborted; loser's ready=0.
  - req inputs are ignored; go to IDLE. Masters drop req in the cycle they see ready.
- **rdata behaviour:** each rdata register holds until its next completion. On writes, rdata is updated with s_rdata (don't-care to the master).
- **Latency:** zero-wait slave (s_ack in first XFER cycle) gives ready 2 cycles after req is first sampled. Back-to-back throughput is one transfer per 3 cycles.
- **Ignored s_ack:** s_ack in IDLE or DONE is ignored.
- **Reset mid-XFER:** s_req drops asynchronously; no ready or bus_err is issued after release.

Test Plan:
1. **CPU zero-wait read:** cpu_req=1, cpu_we=0, addr 0x0000_0010; slave acks in the first XFER cycle with 0x1234_5678.
   -> s_req=1 one cycle, addr 0x10, s_we=0; cpu_ready=1 next cycle, cpu_rdata=0x1234_5678; dma_ready=0; owner=0.
2. **DMA write, 3 wait states:** dma_we=1, addr 0x0000_0200, wdata 0xA5A5_0001.
   -> s_req high 4 cycles with s_addr/s_wdata/s_we stable; dma_ready one cycle after ack; bus_err=0; owner=1.
3. **CPU_PRIO=0, both masters re-requesting continuously:** grant order CPU, DMA, CPU, DMA; each ready pulse is 1 cycle, 3-cycle spacing.
4. **CPU_PRIO=1, same stimulus:** CPU wins every IDLE arbitration while cpu_req=1; DMA is granted only in an IDLE cycle where cpu_req=0.
5. **Timeout, TIMEOUT=16, CPU read, s_ack tied 0:** s_req high exactly 16 cycles; then cpu_ready=1, bus_err=1 together, cpu_rdata=0xDEAD_BEEF. The next request proceeds normally.
6. **Reset mid-XFER:** rst_n=0 in the 2nd wait cycle -> s_req=0 immediately, not waiting for a clock edge. After release, no ready/bus_err is issued; a fresh cpu_req completes normally with owner=0.

Source files
------------

// File: rtl/mio_bus_arbiter.sv
// mio_bus_arbiter: shares one MIO slave between the CPU data port and a DMA master.
// It registers the winning request, runs a single slave transfer with an ack timeout, and pulses ready to the winner.
`default_nettype none

module mio_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 16,
  parameter bit          CPU_PRIO = 1'b1,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_cpu_ready,
  input  logic        i_dma_req,
  input  logic        i_dma_we,
  input  logic [31:0] i_dma_addr,
  input  logic [31:0] i_dma_wdata,
  output logic [31:0] o_dma_rdata,
  output logic        o_dma_ready,
  output logic        o_s_req,
  output logic        o_s_we,
  output logic [31:0] o_s_addr,
  output logic [31:0] o_s_wdata,
  input  logic [31:0] i_s_rdata,
  input  logic        i_s_ack,
  output logic        o_bus_err,
  output logic        o_owner
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_XFER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_last_owner;
  logic             r_owner;
  logic             r_s_req;
  logic             r_s_we;
  logic [31:0]      r_s_addr;
  logic [31:0]      r_s_wdata;
  logic [31:0]      r_cpu_rdata;
  logic [31:0]      r_dma_rdata;
  logic             r_cpu_ready;
  logic             r_dma_ready;
  logic             r_bus_err;

  logic             w_any_req;
  logic             w_grant_dma;
  logic             w_sel_we;
  logic [31:0]      w_sel_addr;
  logic [31:0]      w_sel_wdata;
  logic             w_timeout;
  logic [31:0]      w_rdata_next;

  always_comb begin
    w_any_req   = i_cpu_req | i_dma_req;
    w_grant_dma = i_dma_req;
    // On a tie, round-robin hands the bus to whoever did not have it last.
    if (i_cpu_req && i_dma_req) begin
      w_grant_dma = CPU_PRIO ? 1'b0 : ~r_last_owner;
    end
    w_sel_we     = w_grant_dma ? i_dma_we    : i_cpu_we;
    w_sel_addr   = w_grant_dma ? i_dma_addr  : i_cpu_addr;
    w_sel_wdata  = w_grant_dma ? i_dma_wdata : i_cpu_wdata;
    w_timeout    = (r_cnt == CNT_W'(TIMEOUT - 1));
    w_rdata_next = i_s_ack ? i_s_rdata : ERR_DATA;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_last_owner <= 1'b1;
      r_owner      <= 1'b0;
      r_s_req      <= 1'b0;
      r_s_we       <= 1'b0;
      r_s_addr     <= '0;
      r_s_wdata    <= '0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
      r_cpu_ready  <= 1'b0;
      r_dma_ready  <= 1'b0;
      r_bus_err    <= 1'b0;
    end else begin
      r_cpu_ready <= 1'b0;
      r_dma_ready <= 1'b0;
      r_bus_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_owner      <= w_grant_dma;
            r_last_owner <= w_grant_dma;
            r_s_req      <= 1'b1;
            r_s_we       <= w_sel_we;
            r_s_addr     <= w_sel_addr;
            r_s_wdata    <= w_sel_wdata;
            r_cnt        <= '0;
            r_state      <= ST_XFER;
          end
        end
        ST_XFER: begin
          // An ack on the final allowed cycle still wins over the abort.
          if (i_s_ack || w_timeout) begin
            r_s_req   <= 1'b0;
            r_bus_err <= ~i_s_ack;
            r_state   <= ST_DONE;
            if (r_owner) begin
              r_dma_rdata <= w_rdata_next;
              r_dma_ready <= 1'b1;
            end else begin
              r_cpu_rdata <= w_rdata_next;
              r_cpu_ready <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_cpu_rdata = r_cpu_rdata;
  assign o_cpu_ready = r_cpu_ready;
  assign o_dma_rdata = r_dma_rdata;
  assign o_dma_ready = r_dma_ready;
  assign o_s_req     = r_s_req;
  assign o_s_we      = r_s_we;
  assign o_s_addr    = r_s_addr;
  assign o_s_wdata   = r_s_wdata;
  assign o_bus_err   = r_bus_err;
  assign o_owner     = r_owner;

endmodule

`default_nettype wire

// File: tb/tb_mio_bus_arbiter.sv
// tb_mio_bus_arbiter: directed and randomized checks of mio_bus_arbiter.
// Instance 0 runs round-robin ties (CPU_PRIO=0), and instance 1 runs CPU priority (CPU_PRIO=1).
`default_nettype none

module tb_mio_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req[2], cpu_we[2], dma_req[2], dma_we[2], s_ack[2];
  logic [31:0] cpu_addr[2], cpu_wdata[2], dma_addr[2], dma_wdata[2], s_rdata[2];
  logic [31:0] cpu_rdata[2], dma_rdata[2], s_addr[2], s_wdata[2];
  logic        cpu_ready[2], dma_ready[2], s_req[2], s_we[2], bus_err[2], owner[2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mio_bus_arbiter #(.TIMEOUT(16), .CPU_PRIO(g == 1), .ERR_DATA(32'hDEAD_BEEF)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_cpu_req(cpu_req[g]), .i_cpu_we(cpu_we[g]), .i_cpu_addr(cpu_addr[g]),
      .i_cpu_wdata(cpu_wdata[g]), .o_cpu_rdata(cpu_rdata[g]), .o_cpu_ready(cpu_ready[g]),
      .i_dma_req(dma_req[g]), .i_dma_we(dma_we[g]), .i_dma_addr(dma_addr[g]),
      .i_dma_wdata(dma_wdata[g]), .o_dma_rdata(dma_rdata[g]), .o_dma_ready(dma_ready[g]),
      .o_s_req(s_req[g]), .o_s_we(s_we[g]), .o_s_addr(s_addr[g]), .o_s_wdata(s_wdata[g]),
      .i_s_rdata(s_rdata[g]), .i_s_ack(s_ack[g]), .o_bus_err(bus_err[g]), .o_owner(owner[g])
    );
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    for (int m = 0; m < 2; m++) begin
      cpu_req[m] = 1'b0; cpu_we[m] = 1'b0; cpu_addr[m] = '0; cpu_wdata[m] = '0;
      dma_req[m] = 1'b0; dma_we[m] = 1'b0; dma_addr[m] = '0; dma_wdata[m] = '0;
      s_ack[m]   = 1'b0; s_rdata[m] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if ({s_req[m], s_we[m], cpu_ready[m], dma_ready[m], bus_err[m], owner[m]} !== 6'b0 ||
          s_addr[m] !== 32'h0 || s_wdata[m] !== 32'h0 || cpu_rdata[m] !== 32'h0 || dma_rdata[m] !== 32'h0) begin
        failures++;
        $display("FAIL reset_m%0d: got req=%b ready=%b/%b err=%b owner=%b addr=%h, want all zero",
                 m, s_req[m], cpu_ready[m], dma_ready[m], bus_err[m], owner[m], s_addr[m]);
      end
    end
    rst_n = 1'b1;
  endtask

  // Both masters re-request continuously; exp_dma[t] is the expected winner of grant t.
  task automatic test_tie_arbitration(input int m, input logic [3:0] exp_dma, input logic [3:0] cpu_drop);
    cpu_we[m] = 1'b0; cpu_addr[m] = 32'h100; cpu_wdata[m] = 32'h11;
    dma_we[m] = 1'b1; dma_addr[m] = 32'h200; dma_wdata[m] = 32'h22;
    dma_req[m] = 1'b1; s_ack[m] = 1'b1;
    for (int t = 0; t < 4; t++) begin
      cpu_req[m] = ~cpu_drop[t];
      s_rdata[m] = 32'hC0DE_0000 + 32'(t);
      tick();
      checks++;
      if ({s_req[m], owner[m]} !== {1'b1, exp_dma[t]}) begin
        failures++;
        $display("FAIL tie_grant_m%0d_t%0d: got req=%b owner=%b want req=1 owner=%b", m, t, s_req[m], owner[m], exp_dma[t]);
      end
      checks++;
      if (s_addr[m] !== (exp_dma[t] ? 32'h200 : 32'h100)) begin
        failures++;
        $display("FAIL tie_addr_m%0d_t%0d: got %h want %h", m, t, s_addr[m], exp_dma[t] ? 32'h200 : 32'h100);
      end
      cpu_req[m] = 1'b1;
      tick();
      checks++;
      if ({cpu_ready[m], dma_ready[m], s_req[m]} !== {~exp_dma[t], exp_dma[t], 1'b0}) begin
        failures++;
        $display("FAIL tie_ready_m%0d_t%0d: got cpu=%b dma=%b req=%b want cpu=%b dma=%b req=0",
                 m, t, cpu_ready[m], dma_ready[m], s_req[m], ~exp_dma[t], exp_dma[t]);
      end
      checks++;
      if ((exp_dma[t] ? dma_rdata[m] : cpu_rdata[m]) !== 32'hC0DE_0000 + 32'(t)) begin
        failures++;
        $display("FAIL tie_rdata_m%0d_t%0d: got %h want %h", m, t,
                 exp_dma[t] ? dma_rdata[m] : cpu_rdata[m], 32'hC0DE_0000 + 32'(t));
      end
      tick();
      checks++;
      if ({cpu_ready[m], dma_ready[m]} !== 2'b00) begin
        failures++;
        $display("FAIL tie_pulse_m%0d_t%0d: got ready %b%b want 00", m, t, cpu_ready[m], dma_ready[m]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_cpu_read();
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h0000_0010;
    tick();
    checks++;
    if ({s_req[1], s_we[1], owner[1], cpu_ready[1]} !== 4'b1000 || s_addr[1] !== 32'h10) begin
      failures++;
      $display("FAIL cpu_read_req: got req=%b we=%b owner=%b ready=%b addr=%h want 1 0 0 0 00000010",
               s_req[1], s_we[1], owner[1], cpu_ready[1], s_addr[1]);
    end
    s_ack[1] = 1'b1; s_rdata[1] = 32'h1234_5678;
    tick();
    checks++;
    if ({cpu_ready[1], dma_ready[1], bus_err[1], s_req[1]} !== 4'b1000 || cpu_rdata[1] !== 32'h1234_5678) begin
      failures++;
      $display("FAIL cpu_read_done: got ready=%b dma=%b err=%b req=%b rdata=%h want 1 0 0 0 12345678",
               cpu_ready[1], dma_ready[1], bus_err[1], s_req[1], cpu_rdata[1]);
    end
    cpu_req[1] = 1'b0; s_ack[1] = 1'b0;
    tick();
    checks++;
    if (cpu_ready[1] !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_pulse: got ready=%b want 0", cpu_ready[1]);
    end
  endtask

  task automatic test_dma_write_wait();
    logic [31:0] rd;
    rd = $urandom;
    dma_req[1] = 1'b1; dma_we[1] = 1'b1; dma_addr[1] = 32'h0000_0200; dma_wdata[1] = 32'hA5A5_0001;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if ({s_req[1], s_we[1], owner[1], dma_ready[1]} !== 4'b1110 || s_addr[1] !== 32'h200 || s_wdata[1] !== 32'hA5A5_0001) begin
        failures++;
        $display("FAIL dma_write_hold_%0d: got req=%b we=%b owner=%b ready=%b addr=%h wdata=%h", i,
                 s_req[1], s_we[1], owner[1], dma_ready[1], s_addr[1], s_wdata[1]);
      end
      s_ack[1] = (i == 3); s_rdata[1] = rd;
    end
    tick();
    checks++;
    if ({dma_ready[1], cpu_ready[1], bus_err[1], s_req[1], owner[1]} !== 5'b10001 || dma_rdata[1] !== rd) begin
      failures++;
      $display("FAIL dma_write_done: got ready=%b cpu=%b err=%b req=%b owner=%b rdata=%h want 1 0 0 0 1 %h",
               dma_ready[1], cpu_ready[1], bus_err[1], s_req[1], owner[1], dma_rdata[1], rd);
    end
    dma_req[1] = 1'b0; s_ack[1] = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int high_cycles;
    high_cycles = 0;
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h40; s_ack[1] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (s_req[1] === 1'b1 && cpu_ready[1] === 1'b0) high_cycles++;
    end
    checks++;
    if (high_cycles !== 16) begin
      failures++;
      $display("FAIL timeout_sreq_len: got %0d want 16", high_cycles);
    end
    tick();
    checks++;
    if ({cpu_ready[1], bus_err[1], s_req[1]} !== 3'b110 || cpu_rdata[1] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL timeout_abort: got ready=%b err=%b req=%b rdata=%h want 1 1 0 deadbeef",
               cpu_ready[1], bus_err[1], s_req[1], cpu_rdata[1]);
    end
    cpu_req[1] = 1'b0;
    tick();
    cpu_req[1] = 1'b1; cpu_addr[1] = 32'h44; s_ack[1] = 1'b1; s_rdata[1] = 32'h0BAD_F00D;
    tick();
    tick();
    checks++;
    if ({cpu_ready[1], bus_err[1]} !== 2'b10 || cpu_rdata[1] !== 32'h0BAD_F00D) begin
      failures++;
      $display("FAIL timeout_recover: got ready=%b err=%b rdata=%h want 1 0 0badf00d", cpu_ready[1], bus_err[1], cpu_rdata[1]);
    end
    cpu_req[1] = 1'b0; s_ack[1] = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_xfer();
    int bad;
    bad = 0;
    cpu_req[1] = 1'b1; cpu_we[1] = 1'b0; cpu_addr[1] = 32'h80; s_ack[1] = 1'b0;
    tick();
    tick();
    checks++;
    if (s_req[1] !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_pre: got req=%b want 1", s_req[1]);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (s_req[1] !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_async: got req=%b want 0 before next edge", s_req[1]);
    end
    cpu_req[1] = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if ({s_req[1], cpu_ready[1], dma_ready[1], bus_err[1]} !== 4'b0000) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL rst_mid_quiet: got %0d active cycles want 0", bad);
    end
    cpu_req[1] = 1'b1; cpu_addr[1] = 32'h84; s_ack[1] = 1'b1; s_rdata[1] = 32'h5EED_0001;
    tick();
    tick();
    checks++;
    if ({cpu_ready[1], bus_err[1], owner[1]} !== 3'b100 || cpu_rdata[1] !== 32'h5EED_0001) begin
      failures++;
      $display("FAIL rst_mid_fresh: got ready=%b err=%b owner=%b rdata=%h want 1 0 0 5eed0001",
               cpu_ready[1], bus_err[1], owner[1], cpu_rdata[1]);
    end
    cpu_req[1] = 1'b0; s_ack[1] = 1'b0;
    tick();
  endtask

  // Transaction-level model: a grant at edge g with w wait states puts s_req high
  // on edges g..g+w, pulses ready at g+w+1, and the next arbitration is at g+w+3.
  task automatic test_random(input int m, input int ncyc);
    bit          pend[2], pwe[2];
    logic [31:0] paddr[2], pwdata[2], exp_rd[2];
    bit          busy, hang, win, last, own, lat_we, e_sreq, e_done;
    int          g, w_cnt, next_arb;
    logic [31:0] ack_data, lat_addr, lat_wdata;
    do_reset();
    pend = '{1'b0, 1'b0}; pwe = '{1'b0, 1'b0};
    paddr = '{32'h0, 32'h0}; pwdata = '{32'h0, 32'h0}; exp_rd = '{32'h0, 32'h0};
    busy = 1'b0; hang = 1'b0; win = 1'b0; last = 1'b1; own = 1'b0; lat_we = 1'b0;
    g = 0; w_cnt = 0; next_arb = 0; ack_data = '0; lat_addr = '0; lat_wdata = '0;
    for (int k = 0; k < ncyc; k++) begin
      for (int c = 0; c < 2; c++) begin
        if (!pend[c] && $urandom_range(0, 99) < 60) begin
          pend[c] = 1'b1; pwe[c] = 1'($urandom_range(0, 1)); paddr[c] = $urandom; pwdata[c] = $urandom;
        end
      end
      cpu_req[m] = pend[0]; cpu_we[m] = pwe[0]; cpu_addr[m] = paddr[0]; cpu_wdata[m] = pwdata[0];
      dma_req[m] = pend[1]; dma_we[m] = pwe[1]; dma_addr[m] = paddr[1]; dma_wdata[m] = pwdata[1];
      s_rdata[m] = $urandom;
      if (busy && k > g && k <= g + w_cnt + 1) begin
        s_ack[m] = (k == g + w_cnt + 1) && !hang;
        if (s_ack[m]) ack_data = s_rdata[m];
      end else begin
        s_ack[m] = 1'($urandom_range(0, 1));
      end
      if (!busy && k >= next_arb && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) win = (m == 1) ? 1'b0 : !last;
        else                    win = pend[1];
        busy = 1'b1; g = k; last = win; own = win;
        hang = ($urandom_range(0, 11) == 0);
        w_cnt = hang ? 15 : $urandom_range(0, 3);
        lat_we = pwe[win]; lat_addr = paddr[win]; lat_wdata = pwdata[win];
      end
      tick();
      e_sreq = busy && k <= g + w_cnt;
      e_done = busy && k == g + w_cnt + 1;
      if (e_done) exp_rd[win] = hang ? 32'hDEAD_BEEF : ack_data;
      checks++;
      if ({s_req[m], cpu_ready[m], dma_ready[m], bus_err[m], owner[m]} !==
          {e_sreq, e_done && !win, e_done && win, e_done && hang, own}) begin
        failures++;
        $display("FAIL rand_ctl_m%0d_k%0d: got req/cr/dr/err/own=%b%b%b%b%b want %b%b%b%b%b", m, k,
                 s_req[m], cpu_ready[m], dma_ready[m], bus_err[m], owner[m],
                 e_sreq, e_done && !win, e_done && win, e_done && hang, own);
      end
      checks++;
      if (cpu_rdata[m] !== exp_rd[0] || dma_rdata[m] !== exp_rd[1]) begin
        failures++;
        $display("FAIL rand_rdata_m%0d_k%0d: got cpu=%h dma=%h want cpu=%h dma=%h", m, k,
                 cpu_rdata[m], dma_rdata[m], exp_rd[0], exp_rd[1]);
      end
      if (e_sreq) begin
        checks++;
        if ({s_we[m], s_addr[m], s_wdata[m]} !== {lat_we, lat_addr, lat_wdata}) begin
          failures++;
          $display("FAIL rand_fields_m%0d_k%0d: got we=%b addr=%h wdata=%h want we=%b addr=%h wdata=%h", m, k,
                   s_we[m], s_addr[m], s_wdata[m], lat_we, lat_addr, lat_wdata);
        end
      end
      if (e_done) begin
        pend[win] = 1'b0; busy = 1'b0; next_arb = k + 2;
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    test_reset();
    test_tie_arbitration(0, 4'b1010, 4'b0000);
    test_cpu_read();
    test_dma_write_wait();
    test_tie_arbitration(1, 4'b1000, 4'b1000);
    test_timeout();
    test_reset_mid_xfer();
    test_random(0, 400);
    test_random(1, 400);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
